// File: rtl/mem_pkg.sv
// Shared definitions for the data-port arbiter of the 32 KB banked memory:
// size, sequencer states and the address range check.
package mem_pkg;

  localparam int unsigned MEM_BYTES = 32768;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } arb_state_t;

  // The last legal start address is mem_bytes-8, so an 8-byte access never
  // wraps past the top bank.
  function automatic logic mem_in_range(input logic [63:0] addr,
                                        input int unsigned mem_bytes);
    return addr <= (64'(mem_bytes) - 64'd8);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick; `last` remembers the most recent grant so a tie
// goes to the other port.
module rr_arb2 (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_id,
  output logic       gnt_valid
);

  logic last;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = req[1];
    if (req == 2'b11) gnt_id = ~last;
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last <= 1'b1;
    end else if (take && gnt_valid) begin
      last <= gnt_id;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Shares the memory data port between the CPU memory stage (port 0) and the
// loader/debug writer (port 1), sequencing the 2-edge read latency.
module mem_port_arb
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32768,
  parameter int unsigned AW        = 64,
  parameter int unsigned DW        = 64
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic          p0_err,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic          p1_err,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] maddr,
  output logic          wenable,
  output logic [DW-1:0] wdata,
  output logic          renable,
  input  logic [DW-1:0] valM,
  output logic          busy
);

  arb_state_t    state;
  logic          owner;
  logic          we_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          gnt_id;
  logic          gnt_valid;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_ok;
  logic          resp;
  logic [DW-1:0] resp_data;

  rr_arb2 u_arb (
    .clock     (clock),
    .resetn    (resetn),
    .req       ({p1_req, p0_req}),
    .take      (state == IDLE),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    sel_we    = gnt_id ? p1_we    : p0_we;
    sel_addr  = gnt_id ? p1_addr  : p0_addr;
    sel_wdata = gnt_id ? p1_wdata : p0_wdata;
    sel_ok    = mem_in_range(64'(sel_addr), MEM_BYTES);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner   <= gnt_id;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            err_q   <= ~sel_ok;
            state   <= sel_ok ? ACCESS : RESP;
          end
        end
        ACCESS:  state <= we_q ? RESP : WAIT;
        WAIT:    state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state and latched registers only, so an async reset
  // drops them at once and req never reaches an output combinationally.
  always_comb begin
    busy      = (state != IDLE);
    maddr     = busy ? addr_q  : '0;
    wdata     = busy ? wdata_q : '0;
    wenable   = (state == ACCESS) && we_q;
    renable   = (state == WAIT);
    resp      = (state == RESP);
    resp_data = (resp && !we_q && !err_q) ? valM : '0;
    p0_ack    = resp && !owner;
    p1_ack    = resp &&  owner;
    p0_err    = p0_ack && err_q;
    p1_err    = p1_ack && err_q;
    p0_rdata  = owner ? '0 : resp_data;
    p1_rdata  = owner ? resp_data : '0;
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: a byte-array memory model on the data
// port and a transaction-level reference for arbitration, latency and data.
module tb_mem_port_arb;

  localparam int unsigned MEM_BYTES = 32768;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic        p0_we  = 1'b0, p1_we  = 1'b0;
  logic [63:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
  logic        p0_ack, p1_ack, p0_err, p1_err;
  logic [63:0] p0_rdata, p1_rdata, maddr, wdata;
  logic        wenable, renable, busy;
  logic [63:0] valM = '0;

  int checks = 0;
  int errors = 0;
  bit last_m = 1'b1;

  logic [7:0]  env_mem   [MEM_BYTES] = '{default: 8'h00};
  logic [7:0]  model_mem [MEM_BYTES] = '{default: 8'h00};
  logic [14:0] raddr_q = '0;

  always #5 clock = ~clock;

  mem_port_arb #(.MEM_BYTES(MEM_BYTES), .AW(64), .DW(64)) dut (
    .clock(clock), .resetn(resetn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .maddr(maddr), .wenable(wenable), .wdata(wdata), .renable(renable),
    .valM(valM), .busy(busy)
  );

  // Memory behaviour: write at the edge, address captured at the edge,
  // output register loaded when renable is high.
  always @(posedge clock) begin
    if (wenable)
      for (int k = 0; k < 8; k++) env_mem[maddr[14:0] + 15'(k)] <= wdata[8*k +: 8];
    raddr_q <= maddr[14:0];
    if (renable)
      for (int k = 0; k < 8; k++) valM[8*k +: 8] <= env_mem[raddr_q + 15'(k)];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range_ref(input logic [63:0] a);
    return a <= 64'(MEM_BYTES - 8);
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] a);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = model_mem[int'(a[14:0]) + k];
    return r;
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [63:0] d);
    for (int k = 0; k < 8; k++) model_mem[int'(a[14:0]) + k] = d[8*k +: 8];
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? p0_ack : p1_ack;
  endfunction

  function automatic logic err_of(input int p);
    return (p == 0) ? p0_err : p1_err;
  endfunction

  function automatic logic [63:0] rdata_of(input int p);
    return (p == 0) ? p0_rdata : p1_rdata;
  endfunction

  function automatic int next_owner(input bit [1:0] pend);
    if (pend == 2'b11) return last_m ? 0 : 1;
    return pend[1] ? 1 : 0;
  endfunction

  task automatic drive(input int p, input logic rq, input logic we,
                       input logic [63:0] a, input logic [63:0] d);
    if (p == 0) begin
      p0_req = rq; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = rq; p1_we = we; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {57'b0, p0_ack, p1_ack, p0_err, p1_err, wenable, renable, busy}, 64'd0);
    check({tag, "_maddr"}, maddr, 64'd0);
    check({tag, "_wdata"}, wdata, 64'd0);
    check({tag, "_rdata"}, p0_rdata | p1_rdata, 64'd0);
  endtask

  // Single-port transaction with latency, strobe-count and address checks.
  task automatic do_txn(input int p, input logic we, input logic [63:0] a, input logic [63:0] d);
    bit          exp_err = !in_range_ref(a);
    int          exp_lat = exp_err ? 1 : (we ? 2 : 3);
    logic [63:0] exp_rd  = (exp_err || we) ? 64'd0 : model_read(a);
    int          n = 0, wen = 0, ren = 0;
    bit          got = 0, mbad = 0;
    logic        g_err = 1'b0;
    logic [63:0] g_rd = '0;
    logic [2:0]  other = '0;
    drive(p, 1'b1, we, a, d);
    while (!got && n < 12) begin
      @(posedge clock); n++;
      @(negedge clock);
      if (wenable) wen++;
      if (renable) ren++;
      if (busy && maddr !== a) mbad = 1;
      if (ack_of(p)) begin
        got   = 1;
        g_err = err_of(p);
        g_rd  = rdata_of(p);
        other = {ack_of(1 - p), err_of(1 - p), |rdata_of(1 - p)};
      end
    end
    check("txn_ack_seen", 64'(got), 64'd1);
    check("txn_latency", 64'(n), 64'(exp_lat));
    check("txn_err", 64'(g_err), 64'(exp_err));
    check("txn_rdata", g_rd, exp_rd);
    check("txn_wenable_cycles", 64'(wen), 64'(!exp_err && we));
    check("txn_renable_cycles", 64'(ren), 64'(!exp_err && !we));
    check("txn_maddr_stable", 64'(mbad), 64'd0);
    check("txn_other_quiet", 64'(other), 64'd0);
    drive(p, 1'b0, we, a, d);
    if (!exp_err && we) model_write(a, d);
    last_m = (p != 0);
    @(posedge clock);
    @(negedge clock);
  endtask

  // Both ports request together; with hold, a port re-requests right after
  // its ack so the grant sequence shows the round-robin order.
  task automatic run_both(input logic [1:0] we, input logic [63:0] a0, input logic [63:0] a1,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input int n_acks, input bit hold);
    logic [63:0] aa [2];
    logic [63:0] dd [2];
    bit   [1:0]  pend = 2'b11;
    int          exp_o, got_n = 0, cyc = 0, p_ack;
    bit          mbad = 0;
    logic [63:0] exp_rd;
    bit          exp_err;
    aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1;
    drive(0, 1'b1, we[0], a0, d0);
    drive(1, 1'b1, we[1], a1, d1);
    exp_o = next_owner(pend);
    while (got_n < n_acks && cyc < 10 * n_acks) begin
      @(posedge clock); cyc++;
      @(negedge clock);
      if (busy && maddr !== aa[exp_o]) mbad = 1;
      if (!busy && maddr !== 64'd0) mbad = 1;
      if (p0_ack || p1_ack) begin
        p_ack   = p1_ack ? 1 : 0;
        exp_err = !in_range_ref(aa[exp_o]);
        exp_rd  = (exp_err || we[exp_o]) ? 64'd0 : model_read(aa[exp_o]);
        check("rr_owner", 64'(p_ack), 64'(exp_o));
        check("rr_single_ack", 64'(p0_ack & p1_ack), 64'd0);
        check("rr_err", 64'(err_of(exp_o)), 64'(exp_err));
        check("rr_rdata", rdata_of(exp_o), exp_rd);
        check("rr_other_quiet", {62'b0, err_of(1 - exp_o), |rdata_of(1 - exp_o)}, 64'd0);
        if (!exp_err && we[exp_o]) model_write(aa[exp_o], dd[exp_o]);
        last_m = (exp_o != 0);
        got_n++;
        if (!hold || got_n == n_acks) begin
          drive(exp_o, 1'b0, we[exp_o], aa[exp_o], dd[exp_o]);
          pend[exp_o] = 1'b0;
        end
        if (got_n == n_acks) begin
          drive(0, 1'b0, we[0], a0, d0);
          drive(1, 1'b0, we[1], a1, d1);
          pend = 2'b00;
        end
        if (pend != 2'b00) exp_o = next_owner(pend);
      end
    end
    check("rr_acks_done", 64'(got_n), 64'(n_acks));
    check("rr_maddr_stable", 64'(mbad), 64'd0);
    drive(0, 1'b0, we[0], a0, d0);
    drive(1, 1'b0, we[1], a1, d1);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_strobe(input bit want_wen, output bit ok);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clock);
      if (want_wen ? wenable : renable) ok = 1;
    end
  endtask

  function automatic logic [63:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return 64'(MEM_BYTES - 7 + $urandom_range(0, 6));
    if (r == 1) return {1'b1, 31'($urandom), 32'($urandom)};
    return 64'($urandom_range(0, MEM_BYTES - 8));
  endfunction

  initial begin
    bit ok;
    logic [63:0] d;
    repeat (2) @(negedge clock);
    check_quiet("reset");
    resetn = 1'b1;
    @(negedge clock);

    // Continuous requests from reset: grants alternate p0, p1, ...
    run_both(2'b01, 64'h40, 64'h40, 64'h0102_0304_0506_0708, 64'd0, 6, 1'b1);

    do_txn(0, 1'b1, 64'h10, 64'h1122_3344_5566_7788);
    do_txn(0, 1'b0, 64'h10, 64'd0);
    do_txn(1, 1'b1, 64'h7FF8, 64'hA5A5_A5A5_A5A5_A5A5);
    do_txn(1, 1'b0, 64'h7FF8, 64'd0);
    do_txn(1, 1'b0, 64'h7FF9, 64'd0);
    do_txn(0, 1'b1, 64'h1_0000_0010, 64'hFFFF);
    do_txn(1, 1'b1, 64'h13, 64'hCAFE_F00D_1234_5678);
    do_txn(0, 1'b0, 64'h10, 64'd0);

    // Read racing a queued write to the same address: read wins the tie.
    do_txn(1, 1'b1, 64'h100, 64'h0BAD_0BAD_0BAD_0BAD);
    run_both(2'b10, 64'h100, 64'h100, 64'd0, 64'h600D_600D_600D_600D, 2, 1'b0);
    do_txn(0, 1'b0, 64'h100, 64'd0);

    // Reset during WAIT of a read.
    drive(0, 1'b1, 1'b0, 64'h200, 64'd0);
    wait_strobe(1'b0, ok);
    check("wait_renable", 64'(ok), 64'd1);
    resetn = 1'b0;
    #1;
    check_quiet("rst_wait");
    drive(0, 1'b0, 1'b0, 64'h200, 64'd0);
    @(posedge clock); @(negedge clock);
    check_quiet("rst_wait_hold");
    resetn = 1'b1;
    last_m = 1'b1;
    @(posedge clock); @(negedge clock);

    // Reset during ACCESS of a write: the write must not commit.
    drive(1, 1'b1, 1'b1, 64'h100, 64'hDEAD_BEEF_DEAD_BEEF);
    wait_strobe(1'b1, ok);
    check("wait_wenable", 64'(ok), 64'd1);
    resetn = 1'b0;
    #1;
    check_quiet("rst_access");
    drive(1, 1'b0, 1'b1, 64'h100, 64'd0);
    @(posedge clock); @(negedge clock);
    check_quiet("rst_access_hold");
    resetn = 1'b1;
    last_m = 1'b1;
    @(posedge clock); @(negedge clock);
    run_both(2'b00, 64'h100, 64'h200, 64'd0, 64'd0, 2, 1'b0);

    // Randomized mix of single and contending transactions.
    for (int it = 0; it < 40; it++) begin
      d = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0)
        do_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), rand_addr(), d);
      else
        run_both(2'($urandom_range(0, 3)), rand_addr(), rand_addr(), d, ~d, 2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
